// File: rtl/coreahblite_master_stage_if.sv
// Bus bundle between one AHB-Lite master and its master stage.
// The stage uses the slave modport (it answers the master). The master
// side, or a bench standing in for it, uses the master modport.
interface coreahblite_master_stage_if;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         REMAP;
    logic [15:0]  SLV_SEL;
    logic [15:0]  SLV_AREADY;
    logic [15:0]  SLV_DREADY;
    logic [31:0]  SLV_HRESP;
    logic [511:0] SLV_HRDATA;
    logic         HREADY;
    logic [1:0]   HRESP;
    logic [31:0]  HRDATA;

    modport slave (
        input  HADDR, HTRANS, REMAP, SLV_AREADY, SLV_DREADY, SLV_HRESP, SLV_HRDATA,
        output SLV_SEL, HREADY, HRESP, HRDATA
    );

    modport master (
        output HADDR, HTRANS, REMAP, SLV_AREADY, SLV_DREADY, SLV_HRESP, SLV_HRDATA,
        input  SLV_SEL, HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/coreahblite_master_stage.sv
// Per-master front end of the AHB-Lite matrix.
// It decodes HADDR into a one-hot slave request and tracks which slave owns
// the data phase. It then merges that slave's ready, response and read data
// back to the master. Unmapped accesses go to a built-in default slave that
// returns the two-cycle ERROR response.
// Optional feature: define COREAHBLITE_REMAP_EN to swap slots 0 and 1 while
// REMAP=1. When it is undefined, REMAP is ignored.
module coreahblite_master_stage #(
    parameter int          MEMSPACE = 1,
    parameter logic [15:0] SLAVE_EN = 16'hFFFF
) (
    input logic                        HCLK,
    input logic                        HRESETN,
    coreahblite_master_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dflt_state_e;

    dflt_state_e state_q, state_d;
    logic [3:0]  dp_slot_q;
    logic        dp_valid_q;
    logic        dp_dflt_q;

    logic [3:0]  slot_raw;
    logic [3:0]  slot;
    logic        mapped;
    logic        req;
    logic        hit;
    logic        unmapped;
    logic        dflt_ready;
    logic        hready;
    logic        unused_bits;

    // Address decode: choose the slot field and check that the slot lies in the decoded window.
    assign slot_raw = (MEMSPACE == 2) ? bus.HADDR[27:24] : bus.HADDR[31:28];
    assign mapped   = (MEMSPACE == 2) ? (bus.HADDR[31:28] == 4'h0) : 1'b1;

`ifdef COREAHBLITE_REMAP_EN
    // Remap swaps slots 0 and 1 before the enable check, so dp_slot holds the swapped slot.
    assign slot        = (bus.REMAP && (slot_raw[3:1] == 3'b000)) ? {3'b000, ~slot_raw[0]} : slot_raw;
    assign unused_bits = ^{bus.HADDR[23:0], bus.HTRANS[0]};
`else
    assign slot        = slot_raw;
    assign unused_bits = ^{bus.HADDR[23:0], bus.HTRANS[0], bus.REMAP};
`endif

    // Only NONSEQ/SEQ request a slave. A request to a disabled or out-of-range slot belongs to the default slave.
    assign req         = bus.HTRANS[1];
    assign hit         = req & SLAVE_EN[slot] & mapped;
    assign unmapped    = req & ~hit;
    assign bus.SLV_SEL = hit ? (16'h0001 << slot) : 16'h0000;

    // Merged ready: any address-phase stall, data-phase wait or default-slave first cycle holds the master.
    assign hready     = (&bus.SLV_AREADY) & (&bus.SLV_DREADY) & dflt_ready;
    assign bus.HREADY = hready;

    // Data-phase ownership, captured only when the current address phase completes.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dp_slot_q  <= 4'h0;
            dp_valid_q <= 1'b0;
            dp_dflt_q  <= 1'b0;
        end else if (hready) begin
            dp_slot_q  <= slot;
            dp_valid_q <= hit;
            dp_dflt_q  <= unmapped;
        end
    end

    // Default slave state register.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Default slave next state: ERR1 (not ready) then ERR2 (ready). ERR2 can chain straight into another ERR1.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        dflt_ready = 1'b1;
        case (state_q)
            ST_IDLE: if (hready && unmapped) state_d = ST_ERR1;
            ST_ERR1: begin
                dflt_ready = 1'b0;
                state_d    = ST_ERR2;
            end
            ST_ERR2: state_d = (hready && unmapped) ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Return path: the owning slave's data and response, or the default slave's ERROR.
    always_comb begin
        bus.HRDATA = 32'h0;
        bus.HRESP  = 2'b00;
        if (dp_valid_q) begin
            bus.HRDATA = bus.SLV_HRDATA[{dp_slot_q, 5'd0} +: 32];
            bus.HRESP  = bus.SLV_HRESP[{dp_slot_q, 1'b0} +: 2];
        end else if (dp_dflt_q && (state_q != ST_IDLE)) begin
            bus.HRESP  = 2'b01;
        end
    end

endmodule

// File: tb/tb_coreahblite_master_stage.sv
// Self-checking bench for coreahblite_master_stage (MEMSPACE=1, slot 2 disabled).
// Covers decode vectors from a table, then sequences for: mapped read, chained
// unmapped errors, address-phase stall, data-phase waits, remap, and reset
// while the default slave is in ERR1.
module tb_coreahblite_master_stage;

    logic hclk;
    logic hresetn;
    int   n_tests;
    int   n_fail;

    coreahblite_master_stage_if bus ();

    coreahblite_master_stage #(
        .MEMSPACE (1),
        .SLAVE_EN (16'hFFFB)
    ) dut (
        .HCLK    (hclk),
        .HRESETN (hresetn),
        .bus     (bus.slave)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic [15:0] exp_sel;
    } dec_vec_t;

    dec_vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_remap_data;
        logic [15:0] exp_remap_sel;
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{32'h3000_0010, 2'b10, 16'h0008};
        vecs[1] = '{32'h3000_0010, 2'b11, 16'h0008};
        vecs[2] = '{32'h3000_0010, 2'b00, 16'h0000};
        vecs[3] = '{32'h3000_0010, 2'b01, 16'h0000};
        vecs[4] = '{32'h2000_0000, 2'b10, 16'h0000};
        vecs[5] = '{32'hF000_0000, 2'b10, 16'h8000};
        vecs[6] = '{32'h0FFF_FFFF, 2'b10, 16'h0001};
        vecs[7] = '{32'h1234_5678, 2'b11, 16'h0002};
        vecs[8] = '{32'hA000_0000, 2'b10, 16'h0400};

        hresetn        = 1'b0;
        bus.HADDR      = 32'h0;
        bus.HTRANS     = 2'b00;
        bus.REMAP      = 1'b0;
        bus.SLV_AREADY = 16'hFFFF;
        bus.SLV_DREADY = 16'hFFFF;
        bus.SLV_HRESP  = 32'h0;
        for (int n = 0; n < 16; n++) bus.SLV_HRDATA[32*n +: 32] = 32'hCAFE_0000 | n;
        #2;

        // Decode table, applied while reset is held: SLV_SEL is combinational even in reset.
        for (int i = 0; i < 9; i++) begin
            bus.HADDR  = vecs[i].haddr;
            bus.HTRANS = vecs[i].htrans;
            #1;
            check($sformatf("dec_sel[%0d]", i), {16'h0, bus.SLV_SEL}, {16'h0, vecs[i].exp_sel});
            check($sformatf("dec_rdy[%0d]", i), {31'h0, bus.HREADY}, 32'h1);
        end
        bus.HTRANS = 2'b00;
        #1;
        check("rst_hresp", {30'h0, bus.HRESP}, 32'h0);
        check("rst_hrdata", bus.HRDATA, 32'h0);

        tick();
        hresetn = 1'b1;
        tick();

        // Mapped read of slot 3 with zero wait states.
        bus.HADDR  = 32'h3000_0010;
        bus.HTRANS = 2'b10;
        #1;
        check("rd3_sel", {16'h0, bus.SLV_SEL}, 32'h0008);
        check("rd3_addr_rdy", {31'h0, bus.HREADY}, 32'h1);
        tick();
        bus.HTRANS = 2'b00;
        #1;
        check("rd3_data", bus.HRDATA, 32'hCAFE_0003);
        check("rd3_resp", {30'h0, bus.HRESP}, 32'h0);
        check("rd3_rdy", {31'h0, bus.HREADY}, 32'h1);
        tick();
        check("rd3_idle_data", bus.HRDATA, 32'h0);

        // Two chained unmapped accesses to disabled slot 2: 0/01, 1/01, 0/01, 1/01, then idle.
        bus.HADDR  = 32'h2000_0000;
        bus.HTRANS = 2'b10;
        #1;
        check("err_sel", {16'h0, bus.SLV_SEL}, 32'h0);
        tick();
        check("err1a_rdy", {31'h0, bus.HREADY}, 32'h0);
        check("err1a_resp", {30'h0, bus.HRESP}, 32'h1);
        tick();
        check("err2a_rdy", {31'h0, bus.HREADY}, 32'h1);
        check("err2a_resp", {30'h0, bus.HRESP}, 32'h1);
        tick();
        bus.HTRANS = 2'b00;
        #1;
        check("err1b_rdy", {31'h0, bus.HREADY}, 32'h0);
        check("err1b_resp", {30'h0, bus.HRESP}, 32'h1);
        tick();
        check("err2b_rdy", {31'h0, bus.HREADY}, 32'h1);
        check("err2b_resp", {30'h0, bus.HRESP}, 32'h1);
        tick();
        check("err_idle_rdy", {31'h0, bus.HREADY}, 32'h1);
        check("err_idle_resp", {30'h0, bus.HRESP}, 32'h0);

        // Slot 5 address-phase stall for three cycles. The data phase begins after the fourth edge.
        bus.HADDR         = 32'h5000_0000;
        bus.HTRANS        = 2'b10;
        bus.SLV_AREADY[5] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_rdy[%0d]", i), {31'h0, bus.HREADY}, 32'h0);
            check($sformatf("stall_sel[%0d]", i), {16'h0, bus.SLV_SEL}, 32'h0020);
            check($sformatf("stall_data[%0d]", i), bus.HRDATA, 32'h0);
            tick();
        end
        bus.SLV_AREADY = 16'hFFFF;
        #1;
        check("stall_rel_rdy", {31'h0, bus.HREADY}, 32'h1);
        tick();
        bus.HTRANS = 2'b00;
        #1;
        check("stall_data", bus.HRDATA, 32'hCAFE_0005);
        check("stall_resp", {30'h0, bus.HRESP}, 32'h0);
        tick();

        // Slot 7 adds two data-phase wait states. Its HRESP passes through during the waits.
        bus.HADDR  = 32'h7000_0004;
        bus.HTRANS = 2'b10;
        tick();
        bus.HTRANS           = 2'b00;
        bus.SLV_DREADY[7]    = 1'b0;
        bus.SLV_HRESP[15:14] = 2'b01;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("wait_rdy[%0d]", i), {31'h0, bus.HREADY}, 32'h0);
            check($sformatf("wait_data[%0d]", i), bus.HRDATA, 32'hCAFE_0007);
            check($sformatf("wait_resp[%0d]", i), {30'h0, bus.HRESP}, 32'h1);
            tick();
        end
        bus.SLV_DREADY = 16'hFFFF;
        bus.SLV_HRESP  = 32'h0;
        #1;
        check("wait_done_rdy", {31'h0, bus.HREADY}, 32'h1);
        check("wait_done_data", bus.HRDATA, 32'hCAFE_0007);
        tick();

        // Remap: with the macro, slot 0 is swapped to slot 1. Without it, REMAP has no effect.
`ifdef COREAHBLITE_REMAP_EN
        exp_remap_sel  = 16'h0002;
        exp_remap_data = 32'hCAFE_0001;
`else
        exp_remap_sel  = 16'h0001;
        exp_remap_data = 32'hCAFE_0000;
`endif
        bus.REMAP  = 1'b1;
        bus.HADDR  = 32'h0000_0000;
        bus.HTRANS = 2'b10;
        #1;
        check("remap_sel", {16'h0, bus.SLV_SEL}, {16'h0, exp_remap_sel});
        tick();
        bus.HTRANS = 2'b00;
        bus.REMAP  = 1'b0;
        #1;
        check("remap_data", bus.HRDATA, exp_remap_data);
        tick();

        // Reset while in ERR1 clears immediately. The first cycle after release is IDLE.
        bus.HADDR  = 32'h2000_0000;
        bus.HTRANS = 2'b10;
        tick();
        bus.HTRANS = 2'b00;
        #1;
        check("mid_err1_rdy", {31'h0, bus.HREADY}, 32'h0);
        hresetn = 1'b0;
        #1;
        check("mid_rst_rdy", {31'h0, bus.HREADY}, 32'h1);
        check("mid_rst_resp", {30'h0, bus.HRESP}, 32'h0);
        check("mid_rst_data", bus.HRDATA, 32'h0);
        tick();
        hresetn = 1'b1;
        tick();
        check("post_rst_rdy", {31'h0, bus.HREADY}, 32'h1);
        check("post_rst_resp", {30'h0, bus.HRESP}, 32'h0);
        bus.HADDR  = 32'h3000_0000;
        bus.HTRANS = 2'b10;
        tick();
        bus.HTRANS = 2'b00;
        #1;
        check("post_rst_data", bus.HRDATA, 32'hCAFE_0003);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
